// File: rtl/adc_store_pkg.sv
// Shared types and constants for the ADC channel store: sequencer FSM states,
// sequencer CSR command encodings and a constant-width helper.
package adc_store_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        START,
        RUN,
        STOP
    } seq_state_e;

    localparam logic        SEQ_CSR_CMD_ADDR = 1'b0;
    localparam logic [31:0] SEQ_CMD_RUN      = 32'h1;
    localparam logic [31:0] SEQ_CMD_STOP     = 32'h0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << result) < 64'(value)) result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/adc_avg_lane.sv
// One storage slot: power-of-two boxcar accumulator producing a truncated
// average, a sticky valid flag and a one-cycle update pulse per window.
module adc_avg_lane #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] value,
    output logic              valid,
    output logic              update
);

    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [ACC_W-1:0]  acc_q, acc_d, sum;
    logic [DATA_W-1:0] value_q, value_d;
    logic              valid_q, valid_d;
    logic              update_q, update_d;
    logic              last;

    // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples.
    assign sum = acc_q + ACC_W'(sample);

    generate
        if (AVG_LOG2 == 0) begin : g_no_cnt
            assign last = 1'b1;
        end else begin : g_cnt
            logic [AVG_LOG2-1:0] cnt_q, cnt_d;

            assign last = &cnt_q;

            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (sample_en) begin
                    cnt_d = last ? '0 : cnt_q + AVG_LOG2'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end
        end
    endgenerate

    always_comb begin
        acc_d    = acc_q;
        value_d  = value_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        if (clear) begin
            acc_d = '0;
        end else if (sample_en) begin
            if (last) begin
                value_d  = sum[ACC_W-1 -: DATA_W];
                valid_d  = 1'b1;
                update_d = 1'b1;
                acc_d    = '0;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            update_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            update_q <= update_d;
        end
    end

    assign value  = value_q;
    assign valid  = valid_q;
    assign update = update_q;

endmodule

// File: rtl/adc_channel_store.sv
// ADC front-end storage: drives the sequencer start/stop CSR handshake with
// PLL-lock gating and watchdog restart, and averages NUM_CH contiguous channels.
module adc_channel_store
    import adc_store_pkg::*;
#(
    parameter int NUM_CH      = 9,
    parameter int CH_BASE     = 0,
    parameter int DATA_W      = 12,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT     = 50000,
    parameter int LOCK_SETTLE = 1024
) (
    input  logic                     clk50m,
    input  logic                     reset_n,
    input  logic                     pll_locked,
    input  logic                     rsp_valid,
    input  logic [4:0]               rsp_channel,
    input  logic [DATA_W-1:0]        rsp_data,
    output logic                     csr_address,
    output logic                     csr_write,
    output logic [31:0]              csr_writedata,
    output logic                     csr_read,
    output logic [NUM_CH*DATA_W-1:0] values,
    output logic [NUM_CH-1:0]        value_valid,
    output logic [NUM_CH-1:0]        update,
    output logic                     running,
    output logic [7:0]               stall_cnt
);

    localparam int ST_W = clog2(LOCK_SETTLE) + 1;
    localparam int WD_W = clog2(TIMEOUT) + 1;
    localparam logic [ST_W-1:0] SETTLE_END = ST_W'(LOCK_SETTLE - 1);
    localparam logic [WD_W-1:0] WD_END     = WD_W'(TIMEOUT - 1);
    localparam logic [5:0]      CH_LO      = 6'(CH_BASE);
    localparam logic [5:0]      CH_HI      = 6'(CH_BASE + NUM_CH);

    logic [1:0]      rst_sync_q;
    logic            rst_n;
    seq_state_e      state_q, state_d;
    logic [ST_W-1:0] settle_q, settle_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            restart_q, restart_d;
    logic [7:0]      stall_q, stall_d;
    logic            in_range, accept, clear;
    logic [4:0]      slot;

    // Asynchronous assert, synchronous release of the internal reset.
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign in_range = ({1'b0, rsp_channel} >= CH_LO) && ({1'b0, rsp_channel} < CH_HI);
    assign accept   = rsp_valid && in_range;
    assign clear    = (state_q == START);
    assign slot     = rsp_channel - CH_LO[4:0];

    always_comb begin
        state_d   = state_q;
        settle_d  = '0;
        wd_d      = '0;
        restart_d = restart_q;
        stall_d   = stall_q;
        case (state_q)
            WAIT_LOCK: begin
                if (pll_locked) begin
                    if (settle_q == SETTLE_END) state_d = START;
                    else                        settle_d = settle_q + ST_W'(1);
                end
            end
            START: begin
                state_d   = RUN;
                restart_d = 1'b0;
            end
            RUN: begin
                if (!pll_locked) begin
                    state_d   = STOP;
                    restart_d = 1'b0;
                end else if (accept) begin
                    wd_d = '0;
                end else if (wd_q == WD_END) begin
                    state_d   = STOP;
                    restart_d = 1'b1;
                    if (stall_q != 8'hFF) stall_d = stall_q + 8'd1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            STOP: begin
                state_d = restart_q ? START : WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOCK;
            settle_q  <= '0;
            wd_q      <= '0;
            restart_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            wd_q      <= wd_d;
            restart_q <= restart_d;
            stall_q   <= stall_d;
        end
    end

    assign csr_write     = (state_q == START) || (state_q == STOP);
    assign csr_address   = SEQ_CSR_CMD_ADDR;
    assign csr_writedata = (state_q == START) ? SEQ_CMD_RUN : SEQ_CMD_STOP;
    assign csr_read      = 1'b0;
    assign running       = (state_q == RUN);
    assign stall_cnt     = stall_q;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
            adc_avg_lane #(
                .DATA_W   (DATA_W),
                .AVG_LOG2 (AVG_LOG2)
            ) u_lane (
                .clk       (clk50m),
                .rst_n     (rst_n),
                .clear     (clear),
                .sample_en (accept && (slot == 5'(i))),
                .sample    (rsp_data),
                .value     (values[i*DATA_W +: DATA_W]),
                .valid     (value_valid[i]),
                .update    (update[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_adc_channel_store.sv
// Directed bench for adc_channel_store: a cycle-level behavioural model of
// windows and sequencer handshake checked every cycle, plus literal expectations.
module tb_adc_channel_store;

    localparam int NUM_CH      = 9;
    localparam int CH_BASE     = 0;
    localparam int DATA_W      = 12;
    localparam int AVG_LOG2    = 2;
    localparam int TIMEOUT     = 100;
    localparam int LOCK_SETTLE = 16;
    localparam int WIN         = 1 << AVG_LOG2;

    localparam int M_WAIT  = 0;
    localparam int M_START = 1;
    localparam int M_RUN   = 2;
    localparam int M_STOP  = 3;

    logic                     clk50m = 1'b0;
    logic                     reset_n = 1'b1;
    logic                     pll_locked = 1'b0;
    logic                     rsp_valid = 1'b0;
    logic [4:0]               rsp_channel = '0;
    logic [DATA_W-1:0]        rsp_data = '0;
    logic                     csr_address;
    logic                     csr_write;
    logic [31:0]              csr_writedata;
    logic                     csr_read;
    logic [NUM_CH*DATA_W-1:0] values;
    logic [NUM_CH-1:0]        value_valid;
    logic [NUM_CH-1:0]        update;
    logic                     running;
    logic [7:0]               stall_cnt;

    adc_channel_store #(
        .NUM_CH      (NUM_CH),
        .CH_BASE     (CH_BASE),
        .DATA_W      (DATA_W),
        .AVG_LOG2    (AVG_LOG2),
        .TIMEOUT     (TIMEOUT),
        .LOCK_SETTLE (LOCK_SETTLE)
    ) dut (
        .clk50m        (clk50m),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .rsp_valid     (rsp_valid),
        .rsp_channel   (rsp_channel),
        .rsp_data      (rsp_data),
        .csr_address   (csr_address),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_read      (csr_read),
        .values        (values),
        .value_valid   (value_valid),
        .update        (update),
        .running       (running),
        .stall_cnt     (stall_cnt)
    );

    always #10 clk50m = ~clk50m;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  psum[NUM_CH];
    int  pn[NUM_CH];
    int  exp_val[NUM_CH];
    bit  exp_vv[NUM_CH];
    bit  exp_upd[NUM_CH];
    int  mode = M_WAIT;
    int  lock_age = 0;
    int  idle = 0;
    int  stall = 0;
    bit  restart = 0;
    int  rst_edges = 0;

    always @(posedge clk50m) cyc++;

    always @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_CH; s++) begin
                psum[s] = 0; pn[s] = 0; exp_val[s] = 0; exp_vv[s] = 0; exp_upd[s] = 0;
            end
            mode = M_WAIT; lock_age = 0; idle = 0; stall = 0; restart = 0; rst_edges = 0;
        end else if (rst_edges < 2) begin
            rst_edges++;
        end else begin
            bit acc_ok;
            int s;
            acc_ok = rsp_valid && (int'(rsp_channel) >= CH_BASE) && (int'(rsp_channel) < CH_BASE + NUM_CH);
            for (int k = 0; k < NUM_CH; k++) exp_upd[k] = 0;
            if (mode == M_START) begin
                for (int k = 0; k < NUM_CH; k++) begin psum[k] = 0; pn[k] = 0; end
            end else if (acc_ok) begin
                s = int'(rsp_channel) - CH_BASE;
                psum[s] += int'(rsp_data);
                pn[s]++;
                if (pn[s] == WIN) begin
                    exp_val[s] = psum[s] / WIN;
                    exp_vv[s]  = 1;
                    exp_upd[s] = 1;
                    psum[s] = 0;
                    pn[s]   = 0;
                end
            end
            case (mode)
                M_WAIT: begin
                    if (pll_locked) begin
                        lock_age++;
                        if (lock_age == LOCK_SETTLE) mode = M_START;
                    end else begin
                        lock_age = 0;
                    end
                end
                M_START: begin mode = M_RUN; idle = 0; end
                M_RUN: begin
                    if (!pll_locked) begin
                        mode = M_STOP; restart = 0;
                    end else if (acc_ok) begin
                        idle = 0;
                    end else begin
                        idle++;
                        if (idle == TIMEOUT) begin
                            mode = M_STOP; restart = 1;
                            if (stall < 255) stall++;
                        end
                    end
                end
                default: begin
                    mode = restart ? M_START : M_WAIT;
                    lock_age = 0;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    int unsigned wr_log[$];
    int first_wr_cyc = -1;
    int upd3_cnt = 0;

    always @(negedge clk50m) begin
        logic [NUM_CH*DATA_W-1:0] ev;
        logic [NUM_CH-1:0] evv, eup;
        int ewd;
        for (int s = 0; s < NUM_CH; s++) begin
            ev[s*DATA_W +: DATA_W] = exp_val[s][DATA_W-1:0];
            evv[s] = exp_vv[s];
            eup[s] = exp_upd[s];
        end
        ewd = (mode == M_START) ? 1 : 0;
        chk("values", 128'(values), 128'(ev));
        chk("value_valid", 128'(value_valid), 128'(evv));
        chk("update", 128'(update), 128'(eup));
        chk("running", 128'(running), 128'(mode == M_RUN));
        chk("csr_write", 128'(csr_write), 128'((mode == M_START) || (mode == M_STOP)));
        if (csr_write) chk("csr_writedata", 128'(csr_writedata), 128'(ewd));
        chk("csr_address", 128'(csr_address), 128'(0));
        chk("csr_read", 128'(csr_read), 128'(0));
        chk("stall_cnt", 128'(stall_cnt), 128'(stall));
        if (csr_write) begin
            wr_log.push_back(csr_writedata);
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        if (update[3]) upd3_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk50m);
        #1;
    endtask

    task automatic send(input int ch, input int data);
        rsp_valid   = 1'b1;
        rsp_channel = 5'(ch);
        rsp_data    = DATA_W'(data);
        tick();
        rsp_valid   = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] slot_val(input int s);
        return values[s*DATA_W +: DATA_W];
    endfunction

    initial begin
        int lock_cyc;
        int ok;
        int och[3];
        och[0] = 9; och[1] = 17; och[2] = 31;

        #1 reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();

        // Lock and sequencer start
        pll_locked = 1'b1;
        lock_cyc = cyc;
        for (int i = 0; i < 100 && !running; i++) tick();
        chk("start_running", 128'(running), 128'(1));
        chk("start_latency", 128'(first_wr_cyc - lock_cyc), 128'(16));
        chk("start_single_write", 128'(wr_log.size()), 128'(1));
        if (wr_log.size() > 0) chk("start_writedata", 128'(wr_log[0]), 128'(1));

        // Simple window on channel 3
        send(3, 100); send(3, 101); send(3, 102); send(3, 103);
        chk("avg_101", 128'(slot_val(3)), 128'(101));
        chk("valid_only3", 128'(value_valid), 128'(9'b000001000));
        tick();
        chk("update3_once", 128'(upd3_cnt), 128'(1));

        // Full scale
        for (int i = 0; i < 4; i++) send(3, 4095);
        chk("full_scale", 128'(slot_val(3)), 128'(4095));

        // Interleaved channels 2 and 3
        send(2, 10); send(3, 20); send(2, 11); send(3, 21);
        send(2, 12); send(3, 22); send(2, 13); send(3, 24);
        chk("interleave2", 128'(slot_val(2)), 128'(11));
        chk("interleave3", 128'(slot_val(3)), 128'(21));

        // Partial window, then only out-of-range traffic until the watchdog fires
        send(5, 1000); send(5, 1000);
        for (int i = 0; i < 200 && stall_cnt == 0; i++) send(och[i % 3], 7);
        chk("stall_cnt_1", 128'(stall_cnt), 128'(1));
        ok = 0;
        for (int i = 0; i < 10 && !running; i++) tick();
        chk("restart_running", 128'(running), 128'(1));
        if (wr_log.size() >= 3) begin
            chk("restart_stop_wr", 128'(wr_log[wr_log.size()-2]), 128'(0));
            chk("restart_start_wr", 128'(wr_log[wr_log.size()-1]), 128'(1));
        end else begin
            chk("restart_write_count", 128'(wr_log.size()), 128'(3));
        end
        send(5, 8); send(5, 8);
        chk("partial_discarded", 128'(value_valid[5]), 128'(0));
        send(5, 8); send(5, 8);
        chk("fresh_window", 128'(slot_val(5)), 128'(8));

        // Lock loss
        pll_locked = 1'b0;
        tick(); tick();
        chk("lockloss_running", 128'(running), 128'(0));
        chk("lockloss_stop_wr", 128'(wr_log[wr_log.size()-1]), 128'(0));
        chk("lockloss_kept", 128'(slot_val(3)), 128'(21));

        // Reset in the middle of a window
        send(1, 50); send(1, 50);
        #5 reset_n = 1'b0;
        #1;
        chk("rst_values", 128'(values), 128'(0));
        chk("rst_valid", 128'(value_valid), 128'(0));
        chk("rst_update", 128'(update), 128'(0));
        chk("rst_running", 128'(running), 128'(0));
        chk("rst_stall", 128'(stall_cnt), 128'(0));
        chk("rst_csr_write", 128'(csr_write), 128'(0));
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
